pc_update_ctrl: RTL and testbench

PC_UPDATE_CTRL -- requirements
Module: pc_update_ctrl

---
 rtl/pc_update_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pc_update_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_ctrl.sv
// PC update sequencer: fetch, decode and PC/EPC write control per instruction.
// Optional exception path (EPC save + vector jump) is enabled by PC_UPDATE_EXC_EN.
module pc_update_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [2:0]  op_class,
    input  logic        branch_taken,
    output logic [2:0]  PcSrc,
    output logic        PcWrite,
    output logic        EpcWrite,
    output logic        busy,
    output logic        done,
    output logic [15:0] retired
);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_JR   = 3'b011;

    localparam logic [2:0] SRC_PC4 = 3'b000;
    localparam logic [2:0] SRC_BR  = 3'b001;
    localparam logic [2:0] SRC_JMP = 3'b010;
    localparam logic [2:0] SRC_REG = 3'b011;
`ifdef PC_UPDATE_EXC_EN
    localparam logic [2:0] SRC_EXC = 3'b100;
`endif

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        RESOLVE
`ifdef PC_UPDATE_EXC_EN
        ,
        EXC_EPC,
        EXC_VEC
`endif
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  op_q;
    logic        taken_q;
    logic [15:0] retired_q;

    logic [2:0]  res_src;
    logic        res_write;
    logic [2:0]  src_raw;
    logic        exc_dec;

    // Classes 100-111 (exception and reserved) divert only when the path exists.
`ifdef PC_UPDATE_EXC_EN
    assign exc_dec = op_class[2];
`else
    assign exc_dec = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_SEQ;
            taken_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q    <= op_class;
                taken_q <= branch_taken;
            end
            if (done) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    // Resolution of the latched class; anything non-control-flow leaves PC alone.
    always_comb begin
        res_src   = SRC_PC4;
        res_write = 1'b0;
        case (op_q)
            OP_BR: begin
                res_src   = taken_q ? SRC_BR : SRC_PC4;
                res_write = taken_q;
            end
            OP_JMP: begin
                res_src   = SRC_JMP;
                res_write = 1'b1;
            end
            OP_JR: begin
                res_src   = SRC_REG;
                res_write = 1'b1;
            end
            default: begin
                res_src   = SRC_PC4;
                res_write = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        src_raw  = SRC_PC4;
        PcWrite  = 1'b0;
        EpcWrite = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                src_raw = SRC_PC4;
                PcWrite = mem_ready;
                if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = exc_dec ?
`ifdef PC_UPDATE_EXC_EN
                          EXC_EPC
`else
                          RESOLVE
`endif
                          : RESOLVE;
            end
            RESOLVE: begin
                src_raw = res_src;
                PcWrite = res_write;
                done    = 1'b1;
                state_d = IDLE;
            end
`ifdef PC_UPDATE_EXC_EN
            EXC_EPC: begin
                EpcWrite = 1'b1;
                state_d  = EXC_VEC;
            end
            EXC_VEC: begin
                src_raw = SRC_EXC;
                PcWrite = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The mux select is parked at PC+4 whenever the PC is not being loaded.
    assign PcSrc   = PcWrite ? src_raw : SRC_PC4;
    assign busy    = (state_q != IDLE);
    assign retired = retired_q;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Scoreboard bench for pc_update_ctrl: per-cycle expected output vectors
// are queued at stimulus time and compared as each sequence cycle completes.
module tb_pc_update_ctrl;

`ifdef PC_UPDATE_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        mem_ready;
    logic [2:0]  op_class;
    logic        branch_taken;
    logic [2:0]  PcSrc;
    logic        PcWrite;
    logic        EpcWrite;
    logic        busy;
    logic        done;
    logic [15:0] retired;

    int          checks;
    int          errors;
    logic [15:0] exp_ret;
    logic [6:0]  sb[$];

    pc_update_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mem_ready    (mem_ready),
        .op_class     (op_class),
        .branch_taken (branch_taken),
        .PcSrc        (PcSrc),
        .PcWrite      (PcWrite),
        .EpcWrite     (EpcWrite),
        .busy         (busy),
        .done         (done),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vector layout: {busy, done, PcWrite, PcSrc[2:0], EpcWrite}
    task automatic run_seq(input string name, input logic [2:0] op,
                           input logic bt, input int stall, input bit hold);
        logic [6:0] e;
        logic [6:0] got;
        logic [2:0] s;
        logic       w;
        bit         exc;
        int         n;
        exc = EXC_EN && op[2];
        for (int i = 0; i < stall; i++) sb.push_back(7'b1000000);
        sb.push_back(7'b1010000);
        sb.push_back(7'b1000000);
        if (exc) begin
            sb.push_back(7'b1000001);
            sb.push_back({1'b1, 1'b1, 1'b1, 3'b100, 1'b0});
        end else begin
            s = 3'b000;
            w = 1'b0;
            case (op)
                3'b001: if (bt) begin s = 3'b001; w = 1'b1; end
                3'b010: begin s = 3'b010; w = 1'b1; end
                3'b011: begin s = 3'b011; w = 1'b1; end
                default: begin s = 3'b000; w = 1'b0; end
            endcase
            sb.push_back({1'b1, 1'b1, w, s, 1'b0});
        end
        @(negedge clk);
        start        = 1'b1;
        op_class     = op;
        branch_taken = bt;
        mem_ready    = (stall == 0);
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            mem_ready = (n >= stall);
            if (n == stall + 2) begin
                op_class     = ~op;
                branch_taken = ~bt;
            end
            @(negedge clk);
            e   = sb.pop_front();
            got = {busy, done, PcWrite, PcSrc, EpcWrite};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, n, got, e);
            end
            n++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_ret = exp_ret + 16'd1;
        @(negedge clk);
        checks++;
        if ({busy, retired} !== {1'b0, exp_ret}) begin
            errors++;
            $display("FAIL %s end: busy=%b retired=%h expected busy=0 retired=%h",
                     name, busy, retired, exp_ret);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, PcWrite, PcSrc, EpcWrite, retired} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got %b_%h expected all zero",
                     {busy, done, PcWrite, PcSrc, EpcWrite}, retired);
        end
        reset = 1'b0;
        exp_ret = 16'd0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_sequential();
        run_seq("seq", 3'b000, 1'b0, 0, 1'b0);
        run_seq("seq_bt1", 3'b000, 1'b1, 0, 1'b0);
    endtask

    task automatic test_branch();
        run_seq("br_taken", 3'b001, 1'b1, 0, 1'b0);
        run_seq("br_not", 3'b001, 1'b0, 0, 1'b0);
        run_seq("br_stall", 3'b001, 1'b1, 2, 1'b0);
    endtask

    task automatic test_jump_stall();
        run_seq("jmp_stall3", 3'b010, 1'b0, 3, 1'b0);
        run_seq("jr_stall3", 3'b011, 1'b1, 3, 1'b0);
    endtask

    task automatic test_exception();
        run_seq("exc", 3'b100, 1'b0, 0, 1'b0);
        run_seq("rsv101", 3'b101, 1'b1, 0, 1'b0);
        run_seq("rsv110", 3'b110, 1'b0, 1, 1'b0);
        run_seq("rsv111", 3'b111, 1'b1, 0, 1'b0);
    endtask

    task automatic test_start_busy();
        run_seq("hold_start_jmp", 3'b010, 1'b0, 1, 1'b1);
        run_seq("hold_start_exc", 3'b100, 1'b0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start        = 1'b1;
        op_class     = 3'b001;
        branch_taken = 1'b1;
        mem_ready    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        exp_ret = 16'd0;
        checks++;
        if ({busy, done, PcWrite, PcSrc, EpcWrite, retired} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset: got %b_%h expected all zero",
                     {busy, done, PcWrite, PcSrc, EpcWrite}, retired);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, retired} !== {2'b00, exp_ret}) begin
                errors++;
                $display("FAIL post_reset %0d: busy=%b done=%b retired=%h expected 0 0 %h",
                         i, busy, done, retired, exp_ret);
            end
        end
        run_seq("fresh_after_reset", 3'b010, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic       bt;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            bt = 1'($urandom_range(0, 1));
            run_seq("b2b", op, bt, int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        dut.retired_q = 16'hFFFF;
        exp_ret = 16'hFFFF;
        #1;
        checks++;
        if (retired !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: retired=%h expected ffff", retired);
        end
        run_seq("wrap", 3'b000, 1'b0, 0, 1'b0);
        run_seq("after_wrap", 3'b011, 1'b0, 0, 1'b0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_ret      = 16'd0;
        reset        = 1'b1;
        start        = 1'b0;
        mem_ready    = 1'b0;
        op_class     = 3'b000;
        branch_taken = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_stall();
        test_exception();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
